// File: rtl/booth_free_divider.sv
// Multi-cycle signed restoring divider (MIPS DIV semantics): quotient on Lo, remainder on Hi.
// One quotient bit per cycle on magnitudes, with the signs applied in a final fix-up cycle.
module booth_free_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Dividendo,
  input  logic [WIDTH-1:0] Divisor,
  input  logic             DivStart,
  output logic             DivFim,
  output logic             DivisaoPorZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_div;
  logic             r_qneg;
  logic             r_rneg;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] w_abs_dd;
  logic [WIDTH-1:0] w_abs_dv;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  // MIN_INT negates to itself, which read as unsigned is exactly its magnitude.
  assign w_abs_dd = Dividendo[WIDTH-1] ? (-Dividendo) : Dividendo;
  assign w_abs_dv = Divisor[WIDTH-1]   ? (-Divisor)   : Divisor;

  assign w_shift = {r_rem, r_q[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_div});
  assign w_diff  = w_shift[WIDTH-1:0] - r_div;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state        <= S_IDLE;
      r_rem          <= '0;
      r_q            <= '0;
      r_div          <= '0;
      r_qneg         <= 1'b0;
      r_rneg         <= 1'b0;
      r_cnt          <= '0;
      Hi             <= '0;
      Lo             <= '0;
      DivFim         <= 1'b0;
      DivisaoPorZero <= 1'b0;
    end else begin
      DivFim         <= 1'b0;
      DivisaoPorZero <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (DivStart) begin
            if (Divisor == '0) begin
              DivFim         <= 1'b1;
              DivisaoPorZero <= 1'b1;
            end else begin
              r_q     <= w_abs_dd;
              r_div   <= w_abs_dv;
              r_qneg  <= Dividendo[WIDTH-1] ^ Divisor[WIDTH-1];
              r_rneg  <= Dividendo[WIDTH-1];
              r_rem   <= '0;
              r_cnt   <= CW'(WIDTH);
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_rem <= w_ge ? w_diff : w_shift[WIDTH-1:0];
          r_q   <= {r_q[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= S_FIX;
        end
        S_FIX: begin
          Lo      <= r_qneg ? (-r_q)   : r_q;
          Hi      <= r_rneg ? (-r_rem) : r_rem;
          DivFim  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_free_divider.sv
// Directed and scoreboarded checks of booth_free_divider: results, flags, latency,
// ignored/overlapping starts and mid-operation reset.
module tb_booth_free_divider;

  localparam int unsigned WIDTH = 32;
  localparam logic [31:0] MIN_INT = 32'h8000_0000;
  localparam logic [31:0] MAX_INT = 32'h7FFF_FFFF;

  logic             Clk = 1'b0;
  logic             Reset;
  logic [WIDTH-1:0] Dividendo;
  logic [WIDTH-1:0] Divisor;
  logic             DivStart;
  logic             DivFim;
  logic             DivisaoPorZero;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  int checks = 0;
  int errors = 0;

  booth_free_divider #(.WIDTH(WIDTH)) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Dividendo      (Dividendo),
    .Divisor        (Divisor),
    .DivStart       (DivStart),
    .DivFim         (DivFim),
    .DivisaoPorZero (DivisaoPorZero),
    .Hi             (Hi),
    .Lo             (Lo)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance edge by edge (sampling 1 time unit after each) until DivFim; -1 on timeout.
  task automatic wait_fim(input int lat0, output int lat);
    lat = lat0;
    while (DivFim !== 1'b1 && lat < 80) begin
      @(posedge Clk); #1;
      lat++;
    end
    if (DivFim !== 1'b1) lat = -1;
  endtask

  // Issue a one-cycle DivStart; returns cycles from the accepting edge to the DivFim sample.
  task automatic start_div(input logic [31:0] dd, input logic [31:0] dv, output int lat);
    @(negedge Clk);
    Dividendo = dd;
    Divisor   = dv;
    DivStart  = 1'b1;
    @(posedge Clk); #1;
    DivStart  = 1'b0;
    Dividendo = $urandom;
    Divisor   = $urandom;
    wait_fim(1, lat);
  endtask

  task automatic count_fim(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge Clk); #1;
      if (DivFim === 1'b1) n++;
    end
  endtask

  task automatic div_case(input string tag, input logic [31:0] dd, input logic [31:0] dv,
                          input logic [31:0] eq, input logic [31:0] er);
    int lat;
    start_div(dd, dv, lat);
    chk({tag, "_lat"}, lat, 34);
    chk({tag, "_lo"}, Lo, eq);
    chk({tag, "_hi"}, Hi, er);
    chk({tag, "_dz"}, {31'd0, DivisaoPorZero}, 32'd0);
    @(posedge Clk); #1;
    chk({tag, "_fim_off"}, {31'd0, DivFim}, 32'd0);
  endtask

  initial begin
    int lat;
    int n;
    int a;
    int b;
    logic [31:0] eq;
    logic [31:0] er;
    logic [31:0] corners [5];

    Reset = 1'b1; DivStart = 1'b0; Dividendo = '0; Divisor = '0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_hi", Hi, 32'd0);
    chk("rst_lo", Lo, 32'd0);
    chk("rst_fim", {31'd0, DivFim}, 32'd0);
    chk("rst_dz", {31'd0, DivisaoPorZero}, 32'd0);
    Reset = 1'b0;

    div_case("pos", 32'd100, 32'd7, 32'd14, 32'd2);
    div_case("negdd", -32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
    div_case("negdv", 32'd100, -32'sd7, 32'hFFFF_FFF2, 32'd2);
    div_case("negboth", -32'sd100, -32'sd7, 32'd14, 32'hFFFF_FFFE);
    div_case("pos2", 32'd100, 32'd7, 32'd14, 32'd2);

    // Divide by zero with Hi/Lo holding 2/14.
    start_div(32'd5, 32'd0, lat);
    chk("dz_lat", lat, 1);
    chk("dz_flag", {31'd0, DivisaoPorZero}, 32'd1);
    chk("dz_hi", Hi, 32'd2);
    chk("dz_lo", Lo, 32'd14);
    @(posedge Clk); #1;
    chk("dz_fim_off", {31'd0, DivFim}, 32'd0);
    chk("dz_flag_off", {31'd0, DivisaoPorZero}, 32'd0);

    div_case("min_m1", MIN_INT, 32'hFFFF_FFFF, MIN_INT, 32'd0);
    div_case("min_2", MIN_INT, 32'd2, 32'hC000_0000, 32'd0);
    div_case("max_min", MAX_INT, MIN_INT, 32'd0, MAX_INT);
    div_case("small_big", 32'd3, 32'd10, 32'd0, 32'd3);
    div_case("zero_dd", 32'd0, -32'sd5, 32'd0, 32'd0);

    // DivStart pulsed mid-run (as a divide-by-zero request) must be ignored.
    @(negedge Clk);
    Dividendo = 32'd1000; Divisor = 32'd9; DivStart = 1'b1;
    @(posedge Clk); #1;
    DivStart = 1'b0;
    repeat (9) @(posedge Clk);
    #1;
    Dividendo = 32'd1; Divisor = 32'd0; DivStart = 1'b1;
    @(posedge Clk); #1;
    DivStart = 1'b0;
    wait_fim(11, lat);
    chk("ign_lat", lat, 34);
    chk("ign_dz", {31'd0, DivisaoPorZero}, 32'd0);
    chk("ign_lo", Lo, 32'd111);
    chk("ign_hi", Hi, 32'd1);

    // DivStart raised during the DivFim cycle is accepted at the next edge.
    Dividendo = -32'sd50; Divisor = 32'd4; DivStart = 1'b1;
    @(posedge Clk); #1;
    DivStart = 1'b0;
    chk("b2b_fim_off", {31'd0, DivFim}, 32'd0);
    wait_fim(1, lat);
    chk("b2b_lat", lat, 34);
    chk("b2b_lo", Lo, 32'hFFFF_FFF4);
    chk("b2b_hi", Hi, 32'hFFFF_FFFE);
    count_fim(40, n);
    chk("no_extra_fim", n, 0);

    // Reset partway through abandons the divide.
    @(negedge Clk);
    Dividendo = 32'd77; Divisor = 32'd5; DivStart = 1'b1;
    @(posedge Clk); #1;
    DivStart = 1'b0;
    repeat (14) @(posedge Clk);
    #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    chk("mid_rst_hi", Hi, 32'd0);
    chk("mid_rst_lo", Lo, 32'd0);
    Reset = 1'b0;
    count_fim(40, n);
    chk("mid_rst_nofim", n, 0);
    div_case("after_rst", 32'd77, 32'd5, 32'd15, 32'd2);

    // Scoreboard over corner and random signed pairs.
    corners[0] = 32'd0; corners[1] = 32'd1; corners[2] = 32'hFFFF_FFFF;
    corners[3] = MIN_INT; corners[4] = MAX_INT;
    for (int i = 0; i < 150; i++) begin
      a = (i < 25) ? int'(corners[i % 5]) : int'($urandom);
      b = (i < 25) ? int'(corners[i / 5]) : int'($urandom);
      if (i >= 25 && (i % 3) == 0) b = b >>> 20;
      if (b == 0) b = 3;
      if (a == int'(MIN_INT) && b == -1) begin
        eq = MIN_INT;
        er = 32'd0;
      end else begin
        eq = a / b;
        er = a % b;
      end
      div_case("rand", a, b, eq, er);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
